// File: rtl/gpio_irq.sv
// Debounced GPIO input block with per-pin edge flags and a single level interrupt.
// Pads are synchronized, glitch-filtered by a per-bit counter, and exposed through a small register map.
module gpio_irq #(
    parameter int TOTAL_GPIOS = 8,
    parameter int DEBOUNCE_W  = 8
) (
    input  logic                   mem_clk,
    input  logic                   rst,
    input  logic [TOTAL_GPIOS-1:0] gpio_pad,
    input  logic                   mem_valid,
    input  logic [3:0]             mem_addr,
    input  logic [31:0]            mem_wdata,
    input  logic [3:0]             mem_wstrb,
    output logic [TOTAL_GPIOS-1:0] gpio_ind,
    output logic                   irq,
    output logic                   mem_ready,
    output logic [31:0]            mem_rdata
);

    localparam logic [3:0] ADDR_FILT  = 4'h0;
    localparam logic [3:0] ADDR_RISE  = 4'h1;
    localparam logic [3:0] ADDR_FALL  = 4'h2;
    localparam logic [3:0] ADDR_FLAG  = 4'h3;
    localparam logic [3:0] ADDR_DBNC  = 4'h4;
    localparam logic [3:0] ADDR_IRQEN = 4'h5;

    logic [TOTAL_GPIOS-1:0] sync1_reg;
    logic [TOTAL_GPIOS-1:0] sync2_reg;
    logic [TOTAL_GPIOS-1:0] filt_reg;
    logic [TOTAL_GPIOS-1:0] filt_next;
    logic [TOTAL_GPIOS-1:0] filt_prev_reg;
    logic [TOTAL_GPIOS-1:0] rise_reg;
    logic [TOTAL_GPIOS-1:0] fall_reg;
    logic [TOTAL_GPIOS-1:0] flag_reg;
    logic [TOTAL_GPIOS-1:0] flag_next;
    logic [TOTAL_GPIOS-1:0] edge_set;
    logic [TOTAL_GPIOS-1:0] flag_clr;
    logic [DEBOUNCE_W-1:0]  dbnc_reg;
    logic                   irqen_reg;
    logic                   wr_en;
    logic [31:0]            read_data;
    logic                   unused_wdata;

    // Only the low bits of each write are meaningful; the rest are deliberately dropped.
    assign unused_wdata = &{1'b0, mem_wdata};

    assign wr_en = mem_valid && (mem_wstrb == 4'hF);

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= gpio_pad;
            sync2_reg <= sync1_reg;
        end
    end

    // Each pin owns its counter; the filtered level is collected into one register below.
    generate
        for (genvar gi = 0; gi < TOTAL_GPIOS; gi++) begin : g_dbnc
            logic [DEBOUNCE_W-1:0] cnt_reg;
            logic                  differ;
            logic                  expire;

            assign differ = (sync2_reg[gi] != filt_reg[gi]);
            assign expire = (cnt_reg >= dbnc_reg);
            assign filt_next[gi] = (differ && expire) ? sync2_reg[gi] : filt_reg[gi];

            always_ff @(posedge mem_clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (!differ || expire) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + DEBOUNCE_W'(1);
                end
            end
        end
    endgenerate

    assign edge_set = (filt_reg & ~filt_prev_reg & rise_reg)
                    | (~filt_reg & filt_prev_reg & fall_reg);
    assign flag_clr = (wr_en && mem_addr == ADDR_FLAG) ? mem_wdata[TOTAL_GPIOS-1:0] : '0;
    // A new edge in the same cycle as a W1C must survive the clear.
    assign flag_next = (flag_reg & ~flag_clr) | edge_set;

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            filt_reg      <= '0;
            filt_prev_reg <= '0;
            flag_reg      <= '0;
        end else begin
            filt_reg      <= filt_next;
            filt_prev_reg <= filt_reg;
            flag_reg      <= flag_next;
        end
    end

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            rise_reg  <= '0;
            fall_reg  <= '0;
            dbnc_reg  <= '0;
            irqen_reg <= 1'b0;
        end else if (wr_en) begin
            case (mem_addr)
                ADDR_RISE:  rise_reg  <= mem_wdata[TOTAL_GPIOS-1:0];
                ADDR_FALL:  fall_reg  <= mem_wdata[TOTAL_GPIOS-1:0];
                ADDR_DBNC:  dbnc_reg  <= mem_wdata[DEBOUNCE_W-1:0];
                ADDR_IRQEN: irqen_reg <= mem_wdata[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        read_data = '0;
        if (mem_valid) begin
            case (mem_addr)
                ADDR_FILT:  read_data[TOTAL_GPIOS-1:0] = filt_reg;
                ADDR_RISE:  read_data[TOTAL_GPIOS-1:0] = rise_reg;
                ADDR_FALL:  read_data[TOTAL_GPIOS-1:0] = fall_reg;
                ADDR_FLAG:  read_data[TOTAL_GPIOS-1:0] = flag_reg;
                ADDR_DBNC:  read_data[DEBOUNCE_W-1:0]  = dbnc_reg;
                ADDR_IRQEN: read_data[0]               = irqen_reg;
                default: ;
            endcase
        end
    end

    assign mem_rdata = read_data;
    assign mem_ready = mem_valid;
    assign gpio_ind  = filt_reg;
    assign irq       = irqen_reg & (|flag_reg);

endmodule

// File: tb/tb_gpio_irq.sv
// Scoreboard bench for gpio_irq: reads queue an expected snapshot, a negedge monitor compares it.
module tb_gpio_irq;

    logic        mem_clk;
    logic        rst;
    logic [7:0]  gpio_pad;
    logic        mem_valid;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [7:0]  gpio_ind;
    logic        irq;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        rd_active;
    int          checks;
    int          failures;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        irq;
        logic [7:0]  ind;
    } exp_t;

    exp_t exp_q[$];

    gpio_irq #(.TOTAL_GPIOS(8), .DEBOUNCE_W(8)) dut (
        .mem_clk   (mem_clk),
        .rst       (rst),
        .gpio_pad  (gpio_pad),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .gpio_ind  (gpio_ind),
        .irq       (irq),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb = 4'hF);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = data;
        mem_wstrb = strb;
        tick();
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        mem_wdata = '0;
    endtask

    // Expectation describes the state after the most recent edge; the read consumes one edge.
    task automatic rd(input string name, input logic [3:0] addr, input logic [31:0] exp_rdata,
                      input logic exp_irq, input logic [7:0] exp_ind);
        exp_t e;
        e.name  = name;
        e.rdata = exp_rdata;
        e.irq   = exp_irq;
        e.ind   = exp_ind;
        exp_q.push_back(e);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wstrb = 4'h0;
        rd_active = 1'b1;
        tick();
        mem_valid = 1'b0;
        rd_active = 1'b0;
    endtask

    always @(negedge mem_clk) begin
        if (rd_active && mem_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read: got rdata=%h with no expectation queued", mem_rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (mem_rdata !== e.rdata) begin
                    failures++;
                    $display("FAIL %s rdata: got %h want %h", e.name, mem_rdata, e.rdata);
                end
                checks++;
                if (irq !== e.irq) begin
                    failures++;
                    $display("FAIL %s irq: got %b want %b", e.name, irq, e.irq);
                end
                checks++;
                if (gpio_ind !== e.ind) begin
                    failures++;
                    $display("FAIL %s gpio_ind: got %h want %h", e.name, gpio_ind, e.ind);
                end
                checks++;
                if (mem_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL %s mem_ready: got %b want 1", e.name, mem_ready);
                end
                $display("txn %s addr=%h rdata=%h irq=%b ind=%h", e.name, mem_addr, mem_rdata, irq, gpio_ind);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rd_active = 1'b0;
        rst       = 1'b1;
        gpio_pad  = 8'h00;
        mem_valid = 1'b0;
        mem_addr  = 4'h0;
        mem_wdata = '0;
        mem_wstrb = 4'h0;
        tick();
        rd("reset_filt", 4'h0, 32'h0, 1'b0, 8'h00);
        rst = 1'b0;
        tick();
        rd("reset_flag", 4'h3, 32'h0, 1'b0, 8'h00);

        // Fast path: zero debounce, rising edge on pad 0
        wr(4'h4, 32'h0);
        wr(4'h1, 32'h01);
        wr(4'h5, 32'h1);
        gpio_pad[0] = 1'b1;
        rd("dbnc0_e0", 4'h0, 32'h00, 1'b0, 8'h00);
        rd("dbnc0_e1", 4'h0, 32'h00, 1'b0, 8'h00);
        rd("dbnc0_e2", 4'h0, 32'h00, 1'b0, 8'h00);
        rd("dbnc0_filt", 4'h0, 32'h01, 1'b0, 8'h01);
        rd("dbnc0_flag", 4'h3, 32'h01, 1'b1, 8'h01);
        wr(4'h3, 32'h01);
        rd("dbnc0_clr", 4'h3, 32'h00, 1'b0, 8'h01);

        // Debounce of 4: short glitch rejected, longer pulse accepted
        wr(4'h1, 32'h05);
        wr(4'h4, 32'h4);
        gpio_pad[2] = 1'b1;
        repeat (3) tick();
        gpio_pad[2] = 1'b0;
        repeat (8) tick();
        rd("glitch_filt", 4'h0, 32'h01, 1'b0, 8'h01);
        rd("glitch_flag", 4'h3, 32'h00, 1'b0, 8'h01);
        gpio_pad[2] = 1'b1;
        repeat (6) tick();
        rd("pulse_e5", 4'h0, 32'h01, 1'b0, 8'h01);
        rd("pulse_e6", 4'h0, 32'h05, 1'b0, 8'h05);
        rd("pulse_flag", 4'h3, 32'h04, 1'b1, 8'h05);
        wr(4'h3, 32'h04);

        // Falling edge on pad 7 with W1C in the setting cycle
        wr(4'h2, 32'h80);
        wr(4'h4, 32'h0);
        gpio_pad[7] = 1'b1;
        repeat (5) tick();
        rd("pad7_high", 4'h3, 32'h00, 1'b0, 8'h85);
        gpio_pad[7] = 1'b0;
        repeat (3) tick();
        wr(4'h3, 32'h80);
        rd("set_wins", 4'h3, 32'h80, 1'b1, 8'h05);
        wr(4'h3, 32'h80);
        rd("set_wins_clr", 4'h3, 32'h00, 1'b0, 8'h05);

        // Masked interrupt: flag accumulates, enable reveals it
        wr(4'h5, 32'h0);
        wr(4'h2, 32'h84);
        gpio_pad[2] = 1'b0;
        repeat (4) tick();
        rd("masked_flag", 4'h3, 32'h04, 1'b0, 8'h01);
        wr(4'h5, 32'h1);
        rd("unmasked", 4'h3, 32'h04, 1'b1, 8'h01);
        wr(4'h3, 32'h04);
        rd("unmasked_clr", 4'h3, 32'h00, 1'b0, 8'h01);

        // Access rules: partial strobes, RO, unmapped, upper bits dropped
        wr(4'h1, 32'hFF, 4'b0111);
        rd("partial_strb", 4'h1, 32'h05, 1'b0, 8'h01);
        rd("unmapped", 4'h9, 32'h00, 1'b0, 8'h01);
        wr(4'h0, 32'hFF);
        rd("ro_filt", 4'h0, 32'h01, 1'b0, 8'h01);
        wr(4'h4, 32'hABC);
        rd("dbnc_trunc", 4'h4, 32'hBC, 1'b0, 8'h01);
        wr(4'h5, 32'hFFFF_FFFE);
        rd("irqen_bit0_lo", 4'h5, 32'h0, 1'b0, 8'h01);
        wr(4'h5, 32'h8000_0001);
        rd("irqen_bit0_hi", 4'h5, 32'h1, 1'b0, 8'h01);
        rd("fall_rb", 4'h2, 32'h84, 1'b0, 8'h01);
        wr(4'h4, 32'h0);

        // Reset mid-debounce with every flag pending
        wr(4'h1, 32'hFF);
        wr(4'h2, 32'hFF);
        gpio_pad = 8'hFE;
        repeat (4) tick();
        rd("all_flags", 4'h3, 32'hFF, 1'b1, 8'hFE);
        wr(4'h4, 32'd10);
        gpio_pad = 8'h00;
        repeat (4) tick();
        rst = 1'b1;
        rd("async_rst_flag", 4'h3, 32'h0, 1'b0, 8'h00);
        gpio_pad = 8'h01;
        rd("rst_rise", 4'h1, 32'h0, 1'b0, 8'h00);
        rd("rst_fall", 4'h2, 32'h0, 1'b0, 8'h00);
        rd("rst_dbnc", 4'h4, 32'h0, 1'b0, 8'h00);
        rd("rst_irqen", 4'h5, 32'h0, 1'b0, 8'h00);
        rst = 1'b0;
        repeat (5) tick();
        rd("post_rst_filt", 4'h0, 32'h01, 1'b0, 8'h01);
        rd("post_rst_flag", 4'h3, 32'h00, 1'b0, 8'h01);

        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_irq.md
GPIO_IRQ -- requirements
Module: gpio_irq

Interface
REQ-001 SHALL have parameter TOTAL_GPIOS, default 8, number of pad inputs.
REQ-002 SHALL have parameter DEBOUNCE_W, default 8, width of the debounce count register and per-bit counters.
REQ-003 SHALL have port mem_clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port gpio_pad  input  TOTAL_GPIOS  raw asynchronous pad levels.
REQ-006 SHALL have port mem_valid  input  1  register access strobe.
REQ-007 SHALL have port mem_addr  input  4  word register index.
REQ-008 SHALL have port mem_wdata  input  32  write data.
REQ-009 SHALL have port mem_wstrb  input  4  byte strobes; a write occurs only when mem_valid and all four strobes are 1.
REQ-010 SHALL have port gpio_ind  output  TOTAL_GPIOS  filtered pad level; drives the gpio block input-data port.
REQ-011 SHALL have port irq  output  1  interrupt request, level, active-high.
REQ-012 SHALL have port mem_ready  output  1  equals mem_valid (zero wait states).
REQ-013 SHALL have port mem_rdata  output  32  read data, zero-extended; 0 when mem_valid=0.

Function
REQ-014 SHALL pass each gpio_pad bit through a two-flop synchronizer (sync1, sync2).
REQ-015 SHALL keep per bit a filtered level FILT and a DEBOUNCE_W-bit counter CNT; gpio_ind = FILT.
REQ-016 SHALL, per bit per cycle: if sync2==FILT then CNT<=0; else if CNT>=DBNC then FILT<=sync2, CNT<=0; else CNT<=CNT+1.
REQ-017 SHALL give latency: pad change stable before edge 0 -> FILT changes at edge DBNC+2; DBNC=0 gives 3-edge latency; pulses shorter than DBNC+1 cycles at sync2 SHALL be rejected.
REQ-018 SHALL use >= compare so lowering DBNC mid-count never lets CNT wrap or stall.
REQ-019 SHALL set FLAG[i] on the edge after FILT[i] rises with RISE[i]=1, or falls with FALL[i]=1.
REQ-020 SHALL hold FLAG bits until cleared; write to FLAG clears bits where mem_wdata=1 (W1C).
REQ-021 SHALL give set priority over W1C clear in the same cycle.
REQ-022 SHALL drive irq = IRQEN & (|FLAG), combinational from registers; no extra latency.
REQ-023 SHALL decode registers: 0x0 FILT (RO); 0x1 RISE (RW); 0x2 FALL (RW); 0x3 FLAG (R/W1C); 0x4 DBNC (RW, DEBOUNCE_W bits); 0x5 IRQEN (RW, bit 0).
REQ-024 SHALL ignore writes to RO/unmapped addresses and partial-strobe writes; unmapped reads return 0.
REQ-025 SHALL take register writes from the low bits of mem_wdata, discard upper bits, and apply them on the write-cycle edge.
REQ-026 SHALL not gate edge detection on IRQEN; flags accumulate while irq is masked.

Reset
REQ-027 SHALL, while rst=1, force sync1, sync2, FILT, CNT, RISE, FALL, FLAG, DBNC, IRQEN to 0; gpio_ind=0, irq=0 immediately (asynchronous).
REQ-028 SHALL, on rst deassertion with a pad held high, let FILT rise per REQ-017; no flag sets since RISE=0.
REQ-029 SHALL discard in-progress debounce counts and pending flags on reset mid-operation.

Verification
REQ-030 SHALL cover: DBNC=0, RISE=0x01, IRQEN=1, pad[0] 0->1 -> gpio_ind[0]=1 at edge 2, FLAG=0x01 and irq=1 at edge 3.
REQ-031 SHALL cover: DBNC=4, 3-cycle high glitch on pad[2] -> gpio_ind, FLAG unchanged; 6-cycle high -> gpio_ind[2]=1 at edge 6.
REQ-032 SHALL cover: FALL=0x80, pad[7] 1->0 with W1C write 0x80 to FLAG in the cycle the flag sets -> FLAG[7]=1 remains (set wins).
REQ-033 SHALL cover: IRQEN=0, edge sets FLAG=0x04 -> irq=0; write IRQEN=1 -> irq=1 next cycle; W1C 0x04 -> FLAG=0, irq=0.
REQ-034 SHALL cover: write with mem_wstrb=4'b0111 to RISE -> RISE unchanged; read addr 0x9 -> mem_rdata=0, mem_ready=1.
REQ-035 SHALL cover: assert rst mid-debounce with FLAG=0xFF -> all registers and outputs 0 asynchronously.
